countdown_timer_param: RTL and testbench

Parametrised successor of the microwave timer core. It holds an mm:ss countdown with run/pause/stop/door interlock, field-selectable increment and decrement, preset load, quick-add on start, and a power-level duty-cycle heater output. It sits between the debounced front-panel inputs and the 7-segment display driver and heater/LED logic. It outputs binary minutes and seconds; BCD conversion and display multiplexing happen downstream.

---
 rtl/countdown_timer_param.sv | 248 ++++++++++++++++++++++++
 tb/tb_countdown_timer_param.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer_param.sv
// Countdown timer core: mm:ss countdown with run/pause/stop, door interlock,
// field edits, preset load, quick-add and a power-level heater duty cycle.
// All outputs are registered; panel inputs are rising-edge detected except porta.
module countdown_timer_param #(
  parameter int TICK_DIV   = 100,
  parameter int MAX_MIN    = 99,
  parameter int PWR_LEVELS = 4,
  parameter int QUICK_ADD  = 30,
  parameter int DONE_HOLD  = 3
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           pause,
  input  logic                           stop,
  input  logic                           porta,
  input  logic                           mais,
  input  logic                           menos,
  input  logic [1:0]                     field,
  input  logic                           load,
  input  logic [$clog2(MAX_MIN+1)-1:0]   preset_min,
  input  logic [5:0]                     preset_sec,
  output logic [$clog2(MAX_MIN+1)-1:0]   min_out,
  output logic [5:0]                     sec_out,
  output logic [1:0]                     state_out,
  output logic [$clog2(PWR_LEVELS)-1:0]  power_out,
  output logic                           heater_on,
  output logic                           done
);

  localparam int MW = $clog2(MAX_MIN + 1);
  localparam int PW = $clog2(PWR_LEVELS);
  localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HW = (DONE_HOLD > 1) ? $clog2(DONE_HOLD) : 1;

  localparam logic [MW-1:0] MIN_TOP  = MW'(MAX_MIN);
  localparam logic [PW-1:0] PWR_TOP  = PW'(PWR_LEVELS - 1);
  localparam logic [DW-1:0] DIV_TOP  = DW'(TICK_DIV - 1);
  localparam logic [HW-1:0] HOLD_TOP = HW'(DONE_HOLD - 1);
  localparam logic [5:0]    QA_SEC   = 6'(QUICK_ADD % 60);
  localparam logic [MW:0]   QA_MIN   = (MW+1)'(QUICK_ADD / 60);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state_reg, state_next;
  logic [MW-1:0]   min_reg, min_next;
  logic [5:0]      sec_reg, sec_next;
  logic [PW-1:0]   power_reg, power_next;
  logic [DW-1:0]   div_reg, div_next;
  logic [PW-1:0]   frame_reg, frame_next;
  logic [HW-1:0]   hold_reg, hold_next;
  logic            heater_reg, heater_next;
  logic            done_reg, done_next;
  logic [5:0]      edge_q_reg;

  // Edge detection: bit order {load, menos, mais, stop, pause, start}
  logic [5:0] in_now, act;
  logic start_act, pause_act, stop_act, mais_act, menos_act, load_act;
  assign in_now    = {load, menos, mais, stop, pause, start};
  assign act       = in_now & ~edge_q_reg;
  assign start_act = act[0];
  assign pause_act = act[1];
  assign stop_act  = act[2];
  assign mais_act  = act[3];
  assign menos_act = act[4];
  assign load_act  = act[5];

  logic            tick;
  logic [DW-1:0]   div_adv;
  logic [PW-1:0]   frame_adv;
  logic            time_zero;
  assign tick      = (div_reg == DIV_TOP);
  assign div_adv   = tick ? '0 : div_reg + DW'(1);
  assign frame_adv = (frame_reg == PWR_TOP) ? '0 : frame_reg + PW'(1);
  assign time_zero = (min_reg == '0) && (sec_reg == 6'd0);

  // One-second decrement applied on a divider wrap, borrowing from minutes
  logic [MW-1:0] dec_min;
  logic [5:0]    dec_sec;
  always_comb begin
    dec_min = min_reg;
    dec_sec = sec_reg;
    if (tick) begin
      if (sec_reg != 6'd0) begin
        dec_sec = sec_reg - 6'd1;
      end else if (min_reg != '0) begin
        dec_min = min_reg - MW'(1);
        dec_sec = 6'd59;
      end
    end
  end

  // Quick-add on top of the decremented time, carrying into minutes and saturating at MAX_MIN:59
  logic [6:0]    qa_sec_sum;
  logic          qa_carry;
  logic [MW:0]   qa_min_sum;
  logic [MW-1:0] qa_min;
  logic [5:0]    qa_sec;
  always_comb begin
    qa_sec_sum = {1'b0, dec_sec} + {1'b0, QA_SEC};
    qa_carry   = (qa_sec_sum >= 7'd60);
    qa_min_sum = {1'b0, dec_min} + QA_MIN + {{MW{1'b0}}, qa_carry};
    if (qa_min_sum > {1'b0, MIN_TOP}) begin
      qa_min = MIN_TOP;
      qa_sec = 6'd59;
    end else begin
      qa_min = qa_min_sum[MW-1:0];
      qa_sec = qa_carry ? 6'(qa_sec_sum - 7'd60) : qa_sec_sum[5:0];
    end
  end

  // Next-state and datapath decisions, highest-priority event first
  always_comb begin
    state_next = state_reg;
    min_next   = min_reg;
    sec_next   = sec_reg;
    power_next = power_reg;
    div_next   = div_reg;
    frame_next = frame_reg;
    hold_next  = hold_reg;
    case (state_reg)
      S_IDLE: begin
        if (stop_act) begin
          min_next   = '0;
          sec_next   = 6'd0;
          power_next = PWR_TOP;
        end else if (start_act && !porta && !time_zero) begin
          state_next = S_RUN;
          div_next   = '0;
          frame_next = '0;
        end else if (load_act) begin
          min_next = (preset_min > MIN_TOP) ? MIN_TOP : preset_min;
          sec_next = (preset_sec > 6'd59) ? 6'd59 : preset_sec;
        end else if (mais_act ^ menos_act) begin
          case (field)
            2'd0: begin
              if (mais_act) sec_next = (sec_reg >= 6'd59) ? 6'd59 : sec_reg + 6'd1;
              else          sec_next = (sec_reg == 6'd0) ? 6'd0 : sec_reg - 6'd1;
            end
            2'd1: begin
              if (mais_act) sec_next = (sec_reg >= 6'd50) ? 6'd59 : sec_reg + 6'd10;
              else          sec_next = (sec_reg < 6'd10) ? 6'd0 : sec_reg - 6'd10;
            end
            2'd2: begin
              if (mais_act) min_next = (min_reg >= MIN_TOP) ? MIN_TOP : min_reg + MW'(1);
              else          min_next = (min_reg == '0) ? '0 : min_reg - MW'(1);
            end
            default: begin
              if (mais_act) power_next = (power_reg == PWR_TOP) ? PWR_TOP : power_reg + PW'(1);
              else          power_next = (power_reg == '0) ? '0 : power_reg - PW'(1);
            end
          endcase
        end
      end
      S_RUN: begin
        if (stop_act || porta || pause_act) begin
          state_next = S_PAUSE;
        end else begin
          div_next = div_adv;
          if (tick) frame_next = frame_adv;
          if (start_act) begin
            min_next = qa_min;
            sec_next = qa_sec;
          end else begin
            min_next = dec_min;
            sec_next = dec_sec;
            if (tick && dec_min == '0 && dec_sec == 6'd0) begin
              state_next = S_DONE;
              hold_next  = '0;
            end
          end
        end
      end
      S_PAUSE: begin
        if (stop_act) begin
          state_next = S_IDLE;
          min_next   = '0;
          sec_next   = 6'd0;
        end else if (!porta && (start_act || pause_act)) begin
          state_next = S_RUN;
        end
      end
      default: begin
        if (stop_act || start_act || pause_act) begin
          state_next = S_IDLE;
          min_next   = '0;
          sec_next   = 6'd0;
          div_next   = '0;
          hold_next  = '0;
        end else begin
          div_next = div_adv;
          if (tick) begin
            if (hold_reg == HOLD_TOP) begin
              state_next = S_IDLE;
              min_next   = '0;
              sec_next   = 6'd0;
              hold_next  = '0;
            end else begin
              hold_next = hold_reg + HW'(1);
            end
          end
        end
      end
    endcase
    heater_next = (state_next == S_RUN) && (frame_next <= power_next);
    done_next   = (state_next == S_DONE);
  end

  // State, datapath and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg  <= S_IDLE;
      min_reg    <= '0;
      sec_reg    <= 6'd0;
      power_reg  <= PWR_TOP;
      div_reg    <= '0;
      frame_reg  <= '0;
      hold_reg   <= '0;
      heater_reg <= 1'b0;
      done_reg   <= 1'b0;
      edge_q_reg <= 6'd0;
    end else begin
      state_reg  <= state_next;
      min_reg    <= min_next;
      sec_reg    <= sec_next;
      power_reg  <= power_next;
      div_reg    <= div_next;
      frame_reg  <= frame_next;
      hold_reg   <= hold_next;
      heater_reg <= heater_next;
      done_reg   <= done_next;
      edge_q_reg <= in_now;
    end
  end

  assign min_out   = min_reg;
  assign sec_out   = sec_reg;
  assign state_out = state_reg;
  assign power_out = power_reg;
  assign heater_on = heater_reg;
  assign done      = done_reg;

endmodule

// File: tb/tb_countdown_timer_param.sv
// Directed bench for countdown_timer_param with TICK_DIV = 4.
module tb_countdown_timer_param;

  logic       clock = 1'b0;
  logic       reset, start, pause, stop, porta, mais, menos, load;
  logic [1:0] field;
  logic [6:0] preset_min;
  logic [5:0] preset_sec;
  logic [6:0] min_out;
  logic [5:0] sec_out;
  logic [1:0] state_out;
  logic [1:0] power_out;
  logic       heater_on, done;

  int checks = 0;
  int errors = 0;

  countdown_timer_param #(
    .TICK_DIV(4), .MAX_MIN(99), .PWR_LEVELS(4), .QUICK_ADD(30), .DONE_HOLD(3)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .pause(pause), .stop(stop),
    .porta(porta), .mais(mais), .menos(menos), .field(field), .load(load),
    .preset_min(preset_min), .preset_sec(preset_sec),
    .min_out(min_out), .sec_out(sec_out), .state_out(state_out),
    .power_out(power_out), .heater_on(heater_on), .done(done)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // sel: 0 load, 1 mais, 2 menos, 3 stop; high for one edge then low for one edge
  task automatic pulse(input int sel);
    case (sel)
      0: load = 1'b1;
      1: mais = 1'b1;
      2: menos = 1'b1;
      default: stop = 1'b1;
    endcase
    step();
    load = 1'b0; mais = 1'b0; menos = 1'b0; stop = 1'b0;
    step();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; pause = 1'b0; stop = 1'b0; porta = 1'b0;
    mais = 1'b0; menos = 1'b0; load = 1'b0; field = 2'd0;
    preset_min = 7'd0; preset_sec = 6'd0;
    step(); step();
    check("rst_state", state_out, 0);
    check("rst_min", min_out, 0);
    check("rst_sec", sec_out, 0);
    check("rst_power", power_out, 3);
    check("rst_heater", heater_on, 0);
    check("rst_done", done, 0);
    reset = 1'b0;

    // Basic countdown 0:02 -> DONE -> IDLE
    preset_min = 7'd0; preset_sec = 6'd2;
    pulse(0);
    check("t1_load_sec", sec_out, 2);
    start = 1'b1; step(); start = 1'b0;
    check("t1_run", state_out, 1);
    check("t1_heater_run", heater_on, 1);
    repeat (3) step();
    check("t1_sec_pre", sec_out, 2);
    step();
    check("t1_sec_1", sec_out, 1);
    repeat (4) step();
    check("t1_sec_0", sec_out, 0);
    check("t1_done_state", state_out, 3);
    check("t1_done", done, 1);
    check("t1_heater_done", heater_on, 0);
    repeat (11) step();
    check("t1_still_done", state_out, 3);
    step();
    check("t1_idle", state_out, 0);
    check("t1_done_low", done, 0);

    // Door interlock at 1:00, no lost partial tick
    preset_min = 7'd1; preset_sec = 6'd0;
    pulse(0);
    check("t2_load_min", min_out, 1);
    start = 1'b1; step(); start = 1'b0;
    check("t2_run", state_out, 1);
    step();
    porta = 1'b1; step();
    check("t2_door_pause", state_out, 2);
    check("t2_door_heater", heater_on, 0);
    start = 1'b1; step();
    check("t2_start_door", state_out, 2);
    start = 1'b0; porta = 1'b0; step();
    start = 1'b1; step(); start = 1'b0;
    check("t2_resume", state_out, 1);
    check("t2_resume_heater", heater_on, 1);
    step(); step();
    check("t2_hold_min", min_out, 1);
    check("t2_hold_sec", sec_out, 0);
    step();
    check("t2_tick_min", min_out, 0);
    check("t2_tick_sec", sec_out, 59);

    // Stop from RUN pauses, second stop clears
    stop = 1'b1; step(); stop = 1'b0;
    check("t6_stop_pause", state_out, 2);
    check("t6_stop_keep", sec_out, 59);
    step();
    stop = 1'b1; step(); stop = 1'b0;
    check("t6_stop_idle", state_out, 0);
    check("t6_stop_clr", sec_out, 0);
    step();

    // Field edits and saturation
    field = 2'd1;
    repeat (5) pulse(1);
    check("t3_sec10_x5", sec_out, 50);
    pulse(1);
    check("t3_sec10_sat", sec_out, 59);
    field = 2'd2;
    pulse(2);
    check("t3_min_floor", min_out, 0);
    preset_min = 7'd99; preset_sec = 6'd63;
    pulse(0);
    check("t3_preset_clamp", sec_out, 59);
    pulse(1);
    check("t3_min_ceil", min_out, 99);
    field = 2'd0;
    mais = 1'b1; menos = 1'b1; step();
    mais = 1'b0; menos = 1'b0; step();
    check("t6_both_sec", sec_out, 59);
    field = 2'd3;
    pulse(2); pulse(2);
    check("t5_power1", power_out, 1);

    // Quick-add with carry, heater duty at power 1
    preset_min = 7'd98; preset_sec = 6'd50;
    pulse(0);
    start = 1'b1; step(); start = 1'b0;
    check("t4_run", state_out, 1);
    check("t5_h_f0", heater_on, 1);
    step();
    start = 1'b1; step(); start = 1'b0;
    check("t4_qa_min", min_out, 99);
    check("t4_qa_sec", sec_out, 20);
    step();
    check("t5_h_f0b", heater_on, 1);
    step();
    check("t5_h_f1", heater_on, 1);
    check("t4_tick_sec", sec_out, 19);
    repeat (4) step();
    check("t5_h_f2", heater_on, 0);
    repeat (4) step();
    check("t5_h_f3", heater_on, 0);
    repeat (4) step();
    check("t5_h_f0c", heater_on, 1);
    check("t4_sec16", sec_out, 16);
    start = 1'b1; step(); start = 1'b0;
    check("t4_qa2_sec", sec_out, 46);
    step();
    start = 1'b1; step(); start = 1'b0;
    check("t4_sat_min", min_out, 99);
    check("t4_sat_sec", sec_out, 59);

    // Reset mid-run
    reset = 1'b1; step(); reset = 1'b0;
    check("t6_rst_state", state_out, 0);
    check("t6_rst_min", min_out, 0);
    check("t6_rst_sec", sec_out, 0);
    check("t6_rst_power", power_out, 3);
    check("t6_rst_heater", heater_on, 0);
    check("t6_rst_done", done, 0);
    step();

    // Start refused with door open, then full-power run
    preset_min = 7'd0; preset_sec = 6'd10;
    pulse(0);
    porta = 1'b1; start = 1'b1; step();
    check("t2_idle_door", state_out, 0);
    start = 1'b0; porta = 1'b0; step();
    start = 1'b1; step(); start = 1'b0;
    check("t5_run3", state_out, 1);
    for (int k = 1; k <= 4; k++) begin
      repeat (4) step();
      check("t5_h_max", heater_on, 1);
      check("t5_max_sec", sec_out, 32'(10 - k));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
